// File: rtl/imem_loader_if.sv
// Byte-stream loader bus: receive strobe in, memory write and acknowledge out.
// master = the loader, slave = the surrounding system (UART, memory, core).
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [1:0]  wr_lane;
  logic [31:0] wr_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        core_hold;
  logic        load_err;

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output wr_en, wr_addr, wr_lane, wr_data, tx_valid, tx_data, core_hold, load_err
  );

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  wr_en, wr_addr, wr_lane, wr_data, tx_valid, tx_data, core_hold, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: header count, 128-bit bundles as 4 LE words (lane 3 first), ack byte.
// Optional trailing payload checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [7:0]  ACK_OK      = 8'hAA,
  parameter logic [7:0]  ACK_ERR     = 8'hEE,
  parameter int unsigned MAX_BUNDLES = 16384
) (
  input  logic           clk,
  input  logic           rst,
  imem_loader_if.master  bus
);
  // Wide enough to hold MAX_BUNDLES itself, so a full-size load never wraps.
  localparam int BW = $clog2(MAX_BUNDLES + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR, DATA, CSUM, ACK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {HDR, DATA, ACK, DONE, ERR} state_t;
`endif

  state_t         state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [23:0]    shift_q, shift_d;
  logic [1:0]     lane_q, lane_d;
  logic [BW-1:0]  bundle_q, bundle_d;
  logic [BW-1:0]  n_q, n_d;
  logic           ack_err_q, ack_err_d;
  logic           wr_en_q, wr_en_d;
  logic [13:0]    wr_addr_q, wr_addr_d;
  logic [1:0]     wr_lane_q, wr_lane_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           core_hold_q, core_hold_d;
  logic           load_err_q, load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]     sum_q, sum_d;
`endif

  logic           go_ack;
  logic           ack_fail;
  logic [31:0]    word;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    lane_d      = lane_q;
    bundle_d    = bundle_q;
    n_d         = n_q;
    ack_err_d   = ack_err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_lane_d   = wr_lane_q;
    wr_data_d   = wr_data_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    load_err_d  = load_err_q;
    go_ack      = 1'b0;
    ack_fail    = 1'b0;
    // Earlier three bytes sit in shift_q; the current byte completes the LE word.
    word        = {bus.rx_data, shift_q};
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      HDR: begin
        if (bus.rx_valid) begin
          shift_d    = {bus.rx_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              go_ack  = 1'b1;
`endif
            end else if (word > 32'(MAX_BUNDLES)) begin
              go_ack   = 1'b1;
              ack_fail = 1'b1;
            end else begin
              state_d = DATA;
              n_d     = word[BW-1:0];
            end
          end
        end
      end

      DATA: begin
        if (bus.rx_valid) begin
          shift_d    = {bus.rx_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + bus.rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = 14'(bundle_q);
            wr_lane_d = lane_q;
            wr_data_d = word;
            lane_d    = lane_q - 2'd1;
            if (lane_q == 2'd0) begin
              bundle_d = bundle_q + BW'(1);
              if (bundle_q == n_q - BW'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = CSUM;
`else
                go_ack  = 1'b1;
`endif
              end
            end
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (bus.rx_valid) begin
          go_ack   = 1'b1;
          ack_fail = (bus.rx_data != sum_q);
        end
      end
`endif

      ACK: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ack_err_q ? ERR : DONE;
        end
      end

      default: ;
    endcase

    if (go_ack) begin
      state_d    = ACK;
      tx_valid_d = 1'b1;
      tx_data_d  = ack_fail ? ACK_ERR : ACK_OK;
      ack_err_d  = ack_fail;
      if (ack_fail) load_err_d = 1'b1;
    end

    core_hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      lane_q      <= 2'd3;
      bundle_q    <= '0;
      n_q         <= '0;
      ack_err_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 14'd0;
      wr_lane_q   <= 2'd3;
      wr_data_q   <= 32'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      core_hold_q <= 1'b1;
      load_err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      lane_q      <= lane_d;
      bundle_q    <= bundle_d;
      n_q         <= n_d;
      ack_err_q   <= ack_err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_lane_q   <= wr_lane_d;
      wr_data_q   <= wr_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      core_hold_q <= core_hold_d;
      load_err_q  <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_lane   = wr_lane_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.core_hold = core_hold_q;
  assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads push expected writes/acks,
// a negedge monitor pops and compares every wr_en pulse and tx handshake.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if ifc();

  imem_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [47:0] exp_wr[$];   // {addr[13:0], lane[1:0], data[31:0]}
  logic [7:0]  exp_tx[$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %s: %h ok", name, act);
    end else begin
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  initial begin
    logic [47:0] e;
    logic [7:0]  t;
    forever begin
      @(negedge clk);
      if (ifc.wr_en === 1'b1) begin
        if (exp_wr.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_wr: got addr %h lane %h data %h, required no write",
                   ifc.wr_addr, ifc.wr_lane, ifc.wr_data);
        end else begin
          e = exp_wr.pop_front();
          check("wr", {ifc.wr_addr, ifc.wr_lane, ifc.wr_data}, e);
        end
      end
      if (ifc.tx_valid === 1'b1 && ifc.tx_ready === 1'b1) begin
        if (exp_tx.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_tx: got %h, required no ack", ifc.tx_data);
        end else begin
          t = exp_tx.pop_front();
          check("tx", 48'(ifc.tx_data), 48'(t));
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    @(posedge clk);
    #1;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send(n[8*i +: 8]);
  endtask

  // Payload base, base+1, ... base+15 and the expected four writes for bundle 0.
  task automatic send_bundle0(input logic [7:0] base, input logic [31:0] w3, input logic [31:0] w2,
                              input logic [31:0] w1, input logic [31:0] w0);
    exp_wr.push_back({14'd0, 2'd3, w3});
    exp_wr.push_back({14'd0, 2'd2, w2});
    exp_wr.push_back({14'd0, 2'd1, w1});
    exp_wr.push_back({14'd0, 2'd0, w0});
    for (int i = 0; i < 16; i++) send(base + 8'(i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 64; i++) begin
      if (exp_wr.size() == 0 && exp_tx.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check({name, "_drained"}, 48'(exp_wr.size() + exp_tx.size()), 48'd0);
  endtask

  initial begin
    rst          = 1'b1;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'd0;
    ifc.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en",     48'(ifc.wr_en),     48'd0);
    check("rst_wr_addr",   48'(ifc.wr_addr),   48'd0);
    check("rst_wr_lane",   48'(ifc.wr_lane),   48'd3);
    check("rst_wr_data",   48'(ifc.wr_data),   48'd0);
    check("rst_tx_valid",  48'(ifc.tx_valid),  48'd0);
    check("rst_tx_data",   48'(ifc.tx_data),   48'd0);
    check("rst_core_hold", 48'(ifc.core_hold), 48'd1);
    check("rst_load_err",  48'(ifc.load_err),  48'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // One bundle of bytes 00..0F.
    exp_tx.push_back(8'hAA);
    send_header(32'd1);
    send_bundle0(8'h00, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h78);
`endif
    wait_drain("n1");
    check("n1_core_hold", 48'(ifc.core_hold), 48'd0);
    check("n1_load_err",  48'(ifc.load_err),  48'd0);
    for (int i = 0; i < 8; i++) send(8'h55);   // DONE is terminal: no writes
    check("done_core_hold", 48'(ifc.core_hold), 48'd0);

    // Empty load.
    do_reset();
    exp_tx.push_back(8'hAA);
    send_header(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    wait_drain("n0");
    check("n0_core_hold", 48'(ifc.core_hold), 48'd0);

    // Oversized count 16385.
    do_reset();
    exp_tx.push_back(8'hEE);
    send_header(32'h0000_4001);
    wait_drain("big");
    for (int i = 0; i < 20; i++) send(8'h01);  // ERR is terminal: no writes
    check("big_load_err",  48'(ifc.load_err),  48'd1);
    check("big_core_hold", 48'(ifc.core_hold), 48'd1);
    check("big_tx_valid",  48'(ifc.tx_valid),  48'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good then bad.
    do_reset();
    exp_tx.push_back(8'hAA);
    send_header(32'd1);
    exp_wr.push_back({14'd0, 2'd3, 32'h01010101});
    exp_wr.push_back({14'd0, 2'd2, 32'h01010101});
    exp_wr.push_back({14'd0, 2'd1, 32'h01010101});
    exp_wr.push_back({14'd0, 2'd0, 32'h01010101});
    for (int i = 0; i < 16; i++) send(8'h01);
    send(8'h10);
    wait_drain("csum_ok");
    check("csum_ok_load_err", 48'(ifc.load_err), 48'd0);
    do_reset();
    exp_tx.push_back(8'hEE);
    send_header(32'd1);
    exp_wr.push_back({14'd0, 2'd3, 32'h01010101});
    exp_wr.push_back({14'd0, 2'd2, 32'h01010101});
    exp_wr.push_back({14'd0, 2'd1, 32'h01010101});
    exp_wr.push_back({14'd0, 2'd0, 32'h01010101});
    for (int i = 0; i < 16; i++) send(8'h01);
    send(8'h11);
    wait_drain("csum_bad");
    check("csum_bad_load_err",  48'(ifc.load_err),  48'd1);
    check("csum_bad_core_hold", 48'(ifc.core_hold), 48'd1);
`endif

    // Reset after 9 payload bytes, then a fresh load.
    do_reset();
    exp_wr.push_back({14'd0, 2'd3, 32'h03020100});
    exp_wr.push_back({14'd0, 2'd2, 32'h07060504});
    send_header(32'd1);
    for (int i = 0; i < 9; i++) send(8'(i));
    do_reset();
    check("abort_writes_left", 48'(exp_wr.size()), 48'd0);
    exp_tx.push_back(8'hAA);
    send_header(32'd1);
    send_bundle0(8'h10, 32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h78);
`endif
    wait_drain("abort");
    check("abort_core_hold", 48'(ifc.core_hold), 48'd0);

    // Transmitter stalls 5 cycles in ACK while bytes keep arriving.
    do_reset();
    ifc.tx_ready = 1'b0;
    exp_tx.push_back(8'hAA);
    send_header(32'd1);
    send_bundle0(8'h10, 32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h78);
`endif
    for (int i = 0; i < 20; i++) begin
      if (ifc.tx_valid === 1'b1) break;
      @(posedge clk);
      #1;
    end
    check("stall_tx_valid_up", 48'(ifc.tx_valid), 48'd1);
    for (int k = 0; k < 5; k++) begin
      ifc.rx_valid = 1'b1;
      ifc.rx_data  = 8'hC0 + 8'(k);
      @(negedge clk);
      check("stall_tx_valid",  48'(ifc.tx_valid),  48'd1);
      check("stall_tx_data",   48'(ifc.tx_data),   48'hAA);
      check("stall_core_hold", 48'(ifc.core_hold), 48'd1);
      @(posedge clk);
      #1;
      ifc.rx_valid = 1'b0;
    end
    ifc.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_done_core_hold", 48'(ifc.core_hold), 48'd0);
    check("stall_done_tx_valid",  48'(ifc.tx_valid),  48'd0);
    check("stall_queues_empty",   48'(exp_wr.size() + exp_tx.size()), 48'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
